// File: rtl/timebase_counter_if.sv
// Control/status bundle of the timebase counter: run controls and load
// request from the master, registered count and pulses from the counter.
interface timebase_counter_if #(
    parameter int W = 10
);
    logic         en;
    logic         down;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tick;
    logic         carry;
    logic         load_err;

    modport master (
        output en, down, clear, load, load_val,
        input  count, tick, carry, load_err
    );

    modport slave (
        input  en, down, clear, load, load_val,
        output count, tick, carry, load_err
    );
endinterface

// File: rtl/timebase_counter.sv
// Prescaled modulo up/down counter: a DIV-cycle prescaler produces a tick,
// and each tick steps a modulo-MOD counter whose wrap raises carry.
module timebase_counter #(
    parameter int DIV = 100000,
    parameter int MOD = 1000,
    parameter int W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    timebase_counter_if.slave bus
);
    localparam int           PW     = $clog2(DIV);
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [W-1:0]  C_LAST = W'(MOD - 1);
    // One extra bit so MOD == 2**W still compares correctly
    localparam logic [W:0]    C_MOD  = (W + 1)'(MOD);

    logic [PW-1:0] p;
    logic [W-1:0]  count_q;
    logic          tick_q;
    logic          carry_q;
    logic          load_err_q;
    logic          load_ok;

    assign load_ok = ({1'b0, bus.load_val} < C_MOD);

    // Priority reset > clear > load > enabled step; direction is sampled
    // only on the stepping edge, so toggling it mid-interval leaves p alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            p          <= '0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            carry_q    <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.clear) begin
            p       <= '0;
            count_q <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (bus.load) begin
            p       <= '0;
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
            if (load_ok) begin
                count_q <= bus.load_val;
            end else begin
                load_err_q <= 1'b1;
            end
        end else if (bus.en) begin
            if (p == P_LAST) begin
                p      <= '0;
                tick_q <= 1'b1;
                if (!bus.down) begin
                    if (count_q == C_LAST) begin
                        count_q <= '0;
                        carry_q <= 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                        carry_q <= 1'b0;
                    end
                end else begin
                    if (count_q == '0) begin
                        count_q <= C_LAST;
                        carry_q <= 1'b1;
                    end else begin
                        count_q <= count_q - 1'b1;
                        carry_q <= 1'b0;
                    end
                end
            end else begin
                p       <= p + 1'b1;
                tick_q  <= 1'b0;
                carry_q <= 1'b0;
            end
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.tick     = tick_q;
    assign bus.carry    = carry_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_timebase_counter.sv
// Directed table-driven bench for timebase_counter with DIV=4, MOD=5, W=3.
module tb_timebase_counter;
    logic clk;
    logic reset;

    timebase_counter_if #(.W(3)) bus ();

    timebase_counter #(.DIV(4), .MOD(5), .W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       down;
        logic       clear;
        logic       load;
        logic [2:0] load_val;
        logic [2:0] exp_count;
        logic       exp_tick;
        logic       exp_carry;
        logic       exp_err;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic addVec(input logic r, input logic e, input logic d, input logic c,
                          input logic l, input logic [2:0] lv, input logic [2:0] ec,
                          input logic et, input logic eca, input logic eerr, input string tag);
        vec_t v;
        v.rst = r; v.en = e; v.down = d; v.clear = c; v.load = l; v.load_val = lv;
        v.exp_count = ec; v.exp_tick = et; v.exp_carry = eca; v.exp_err = eerr; v.tag = tag;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset        = v.rst;
        bus.en       = v.en;
        bus.down     = v.down;
        bus.clear    = v.clear;
        bus.load     = v.load;
        bus.load_val = v.load_val;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [5:0] act;
        logic [5:0] exp;
        act = {bus.count, bus.tick, bus.carry, bus.load_err};
        exp = {v.exp_count, v.exp_tick, v.exp_carry, v.exp_err};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s vec=%0d got count=%0d tick=%b carry=%b err=%b want count=%0d tick=%b carry=%b err=%b",
                     v.tag, idx, bus.count, bus.tick, bus.carry, bus.load_err,
                     v.exp_count, v.exp_tick, v.exp_carry, v.exp_err);
        end
    endtask

    initial begin
        int cycles;
        bit seen;
        reset = 1'b1; bus.en = 1'b0; bus.down = 1'b0;
        bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0;

        addVec(1,0,0,0,0,0, 0,0,0,0, "reset");
        for (int k = 1; k <= 20; k++)
            addVec(0,1,0,0,0,0, 3'((k / 4) % 5), (k % 4) == 0, k == 20, 0, "up_run");
        for (int k = 1; k <= 4; k++)
            addVec(0,1,1,0,0,0, (k == 4) ? 3'd4 : 3'd0, k == 4, k == 4, 0, "down_wrap");
        for (int k = 1; k <= 4; k++)
            addVec(0,1,1,0,0,0, (k == 4) ? 3'd3 : 3'd4, k == 4, 0, 0, "down_step");
        addVec(0,1,0,0,1,6, 3,0,0,1, "load_out_of_range");
        addVec(0,1,0,1,0,0, 0,0,0,1, "clear_keeps_err");
        for (int k = 1; k <= 3; k++)
            addVec(0,1,0,0,0,0, 0,0,0,1, "pre_load_run");
        addVec(0,1,0,0,1,3, 3,0,0,1, "load_on_step_edge");
        for (int k = 1; k <= 4; k++)
            addVec(0,1,0,0,0,0, (k == 4) ? 3'd4 : 3'd3, k == 4, 0, 1, "after_load");
        for (int k = 1; k <= 2; k++)
            addVec(0,1,0,0,0,0, 4,0,0,1, "pre_freeze");
        for (int k = 1; k <= 10; k++)
            addVec(0,0,0,0,0,0, 4,0,0,1, "freeze");
        addVec(0,1,0,0,0,0, 4,0,0,1, "resume");
        addVec(0,1,0,0,0,0, 0,1,1,1, "resume_wrap");
        for (int k = 1; k <= 3; k++)
            addVec(0,1,0,0,0,0, 0,0,0,1, "pre_clear_load");
        addVec(0,1,0,1,1,2, 0,0,0,1, "clear_beats_load");
        for (int k = 1; k <= 4; k++)
            addVec(0,1,0,0,0,0, (k == 4) ? 3'd1 : 3'd0, k == 4, 0, 1, "after_clear");
        addVec(1,1,0,0,0,0, 0,0,0,0, "reset_clears_err");
        for (int k = 1; k <= 3; k++)
            addVec(0,1,0,0,0,0, 0,0,0,0, "pre_reset_step");
        addVec(1,1,0,0,0,0, 0,0,0,0, "reset_on_step");
        for (int k = 1; k <= 4; k++)
            addVec(0,1,0,0,0,0, (k == 4) ? 3'd1 : 3'd0, k == 4, 0, 0, "after_reset");
        addVec(0,1,1,0,0,0, 1,0,0,0, "down_toggle");
        addVec(0,1,0,0,0,0, 1,0,0,0, "down_toggle");
        addVec(0,1,1,0,0,0, 1,0,0,0, "down_toggle");
        addVec(0,1,0,0,0,0, 2,1,0,0, "down_sampled_up");
        addVec(0,1,0,0,0,0, 2,0,0,0, "down_hold");
        addVec(0,1,0,0,0,0, 2,0,0,0, "down_hold");
        addVec(0,1,0,0,0,0, 2,0,0,0, "down_hold");
        addVec(0,1,1,0,0,0, 1,1,0,0, "down_sampled_dn");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Free-running: next tick must come exactly 4 edges later and last one cycle
        @(negedge clk);
        bus.en = 1'b1; bus.down = 1'b0;
        cycles = 0;
        seen = 0;
        while (!seen && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.tick === 1'b1) seen = 1;
        end
        total++;
        if (!seen || cycles != 4 || bus.count !== 3'd2) begin
            bad++;
            $display("[TB] FAIL tick_latency got seen=%0d cycles=%0d count=%0d want seen=1 cycles=4 count=2",
                     seen, cycles, bus.count);
        end
        @(posedge clk);
        #1;
        total++;
        if (bus.tick !== 1'b0 || bus.count !== 3'd2) begin
            bad++;
            $display("[TB] FAIL tick_width got tick=%b count=%0d want tick=0 count=2", bus.tick, bus.count);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/timebase_counter.md
TIMEBASE_COUNTER -- requirements
Module: timebase_counter

Parameters
REQ-001 The block SHALL have parameter DIV, default 100000, meaning enabled clock cycles per tick, legal range 2 or more.
REQ-002 The block SHALL have parameter MOD, default 1000, meaning counter modulus, legal range 2 or more.
REQ-003 The block SHALL have parameter W, default 10, meaning counter width, with 2^W >= MOD required.

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: run enable; low freezes the prescaler and the counter.
REQ-007 The block SHALL have port down, input, 1 bit: count direction; 0 = up, 1 = down.
REQ-008 The block SHALL have port clear, input, 1 bit: synchronous clear of the prescaler and the counter.
REQ-009 The block SHALL have port load, input, 1 bit: load strobe for load_val.
REQ-010 The block SHALL have port load_val, input, W bits: value to load.
REQ-011 The block SHALL have port count, output, W bits: registered counter value.
REQ-012 The block SHALL have port tick, output, 1 bit: one-cycle registered pulse per DIV enabled cycles.
REQ-013 The block SHALL have port carry, output, 1 bit: one-cycle registered pulse on wrap (MOD-1 to 0 up, or 0 to MOD-1 down).
REQ-014 The block SHALL have port load_err, output, 1 bit: sticky flag set by an out-of-range load.

Function
REQ-015 The internal prescaler p SHALL be ceil(log2(DIV)) bits wide and range 0..DIV-1.
REQ-016 Per-edge priority SHALL be: reset > clear > load > enabled prescaler step.
REQ-017 On a clear edge: p <= 0; count <= 0; tick <= 0; carry <= 0; load_err unchanged.
REQ-018 On a load edge with load_val < MOD: count <= load_val; p <= 0; tick <= 0; carry <= 0.
REQ-019 On a load edge with load_val >= MOD: count unchanged; p <= 0; tick <= 0; carry <= 0; load_err <= 1.
REQ-020 Enabled edge with p != DIV-1 (en=1, no reset/clear/load): p <= p+1; tick <= 0; carry <= 0.
REQ-021 Enabled edge with p == DIV-1: p <= 0; tick <= 1; count steps on the same edge.
REQ-022 Up step: count == MOD-1 gives count <= 0 and carry <= 1; otherwise count <= count+1 and carry <= 0.
REQ-023 Down step: count == 0 gives count <= MOD-1 and carry <= 1; otherwise count <= count-1 and carry <= 0.
REQ-024 Timing: tick and carry SHALL rise on the same edge as the count update; each SHALL be high for exactly one cycle.
REQ-025 Latency: the first tick SHALL go high on the DIV-th enabled edge after reset, clear or load.
REQ-026 Disabled edge (en=0, no reset/clear/load): p and count hold; tick <= 0; carry <= 0.
REQ-027 The down input SHALL be sampled only on the stepping edge; changing it mid-interval SHALL NOT disturb p.
REQ-028 load_err SHALL clear only on reset.
REQ-029 The counter SHALL never hold a value >= MOD.

Reset
REQ-030 On a reset edge: p <= 0; count <= 0; tick <= 0; carry <= 0; load_err <= 0.
REQ-031 Reset SHALL override all inputs on that edge, including mid-interval and coincident with a step.
REQ-032 Counting SHALL resume from p=0 on the first edge after reset deasserts.

Verification (DIV=4, MOD=5, W=3)
REQ-033 Reset, then en=1, down=0 for 20 edges: tick high on edges 4, 8, 12, 16, 20; count 1, 2, 3, 4, 0; carry high only on edge 20.
REQ-034 From count=0, down=1 with a tick: count becomes 4 with carry=1; on the next tick, count becomes 3 with carry=0.
REQ-035 Pulse load=1 with load_val=6: count unchanged and load_err=1; the flag persists through clear and clears only on reset.
REQ-036 load_val=3 applied on the edge where p==3 with en=1: count=3, no tick; the next tick arrives 4 edges later with count=4.
REQ-037 en=0 for 10 edges mid-interval: count and p frozen, tick=0; after re-enable, the tick arrives after the remaining cycles only.
REQ-038 clear and load asserted together with a pending step: count=0, tick=0, carry=0; clear wins.
